// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types for the RV64I hazard scoreboard: entry layout, latency codes, forwarding constants.
// No timing of its own; types only, no flow control.
package rv_pipe_pkg;
  localparam int AW          = 5;
  localparam int LATW        = 4;
  localparam int FWD_REGFILE = 0;

  typedef enum logic [LATW-1:0] {
    LAT_ALU  = 4'd1,
    LAT_LOAD
  } lat_e;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd;
    logic [LATW-1:0] lat;
  } sb_entry_t;
endpackage

// File: rtl/sb_src_check.sv
// One-source lookup against the in-flight writer array: youngest match wins, hazard if not yet forwardable.
// Purely combinational (zero latency); no flow control.
module sb_src_check
  import rv_pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int SELW  = $clog2(DEPTH + 1)
) (
  input  logic                  [AW-1:0] rs,
  input  logic                           used,
  input  sb_entry_t [DEPTH-1:0]          entries,
  output logic                           hazard,
  output logic                  [SELW-1:0] sel
);

  logic found;

  always_comb begin
    found  = 1'b0;
    hazard = 1'b0;
    sel    = SELW'(FWD_REGFILE);
    // Lower index is younger, so the first hit shadows any older writer of the same register.
    for (int s = 0; s < DEPTH; s++) begin
      if (!found && entries[s].valid && entries[s].rd == rs && used && rs != '0) begin
        found = 1'b1;
        if (s + 1 >= int'(entries[s].lat)) sel = SELW'(s + 1);
        else hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard detection and EX forwarding-select generation over a shift-register scoreboard of writers.
// Stall is combinational (zero latency), selects registered one cycle after issue; post-ID stages never stall.
module hazard_scoreboard
  import rv_pipe_pkg::*;
#(
  parameter int NSRC        = 2,
  parameter int AW          = rv_pipe_pkg::AW,
  parameter int DEPTH       = 2,
  parameter int LOAD_LAT    = 2,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNTW        = 32,
  parameter int SELW        = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [NSRC*AW-1:0]     id_rs,
  input  logic [NSRC-1:0]        id_rs_used,
  input  logic [AW-1:0]          id_rd,
  input  logic                   id_regwrite,
  input  logic                   id_is_load,
  input  logic                   flush,
  input  logic                   cnt_clear,
  output logic                   stall,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   idex_bubble,
  output logic [NSRC*SELW-1:0]   ex_fwd_sel,
  output logic [CNTW-1:0]        stall_count
);

  sb_entry_t [DEPTH-1:0]  sb;
  sb_entry_t              new_ent;
  logic [NSRC-1:0]        haz;
  logic [NSRC*SELW-1:0]   sel_c;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    sb_src_check #(
      .DEPTH (DEPTH),
      .SELW  (SELW)
    ) u_chk (
      .rs      (id_rs[g*AW +: AW]),
      .used    (id_rs_used[g]),
      .entries (sb),
      .hazard  (haz[g]),
      .sel     (sel_c[g*SELW +: SELW])
    );
  end

  // A taken branch must redirect even if the squashed consumer had a hazard.
  assign stall       = id_valid & ~flush & (|haz) & ~rst;
  assign pc_write    = ~stall;
  assign ifid_write  = ~stall;
  assign idex_bubble = stall | flush;

  always_comb begin
    new_ent = '0;
    if (id_valid && id_regwrite && id_rd != '0 && !stall && !flush) begin
      new_ent.valid = 1'b1;
      new_ent.rd    = id_rd;
      new_ent.lat   = id_is_load ? LATW'(LOAD_LAT) : LAT_ALU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb          <= '0;
      ex_fwd_sel  <= '0;
      stall_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        sb[i+1] <= (flush && i < FLUSH_DEPTH) ? '0 : sb[i];
      end
      sb[0]      <= new_ent;
      ex_fwd_sel <= (stall || flush || !id_valid) ? '0 : sel_c;
      if (cnt_clear) stall_count <= '0;
      else if (stall && stall_count != {CNTW{1'b1}}) stall_count <= stall_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven bench for hazard_scoreboard; forwarding selects are queued at issue and checked a cycle later.
module tb_hazard_scoreboard;
  localparam int NSRC = 2, AW = 5, DEPTH = 2, LOAD_LAT = 2, FLUSH_DEPTH = 1, CNTW = 3, SELW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 id_valid;
  logic [NSRC*AW-1:0]   id_rs;
  logic [NSRC-1:0]      id_rs_used;
  logic [AW-1:0]        id_rd;
  logic                 id_regwrite;
  logic                 id_is_load;
  logic                 flush;
  logic                 cnt_clear;
  logic                 stall;
  logic                 pc_write;
  logic                 ifid_write;
  logic                 idex_bubble;
  logic [NSRC*SELW-1:0] ex_fwd_sel;
  logic [CNTW-1:0]      stall_count;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NSRC(NSRC), .AW(AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT),
    .FLUSH_DEPTH(FLUSH_DEPTH), .CNTW(CNTW), .SELW(SELW)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load), .flush(flush),
    .cnt_clear(cnt_clear), .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_bubble(idex_bubble), .ex_fwd_sel(ex_fwd_sel), .stall_count(stall_count)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs0, rs1;
    logic [1:0] used;
    logic [4:0] rd;
    logic       rw, ld, fl, clr, rs;
    logic       st;
    logic [1:0] s0, s1;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] exp_q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         exp_cnt = 0;

  function automatic vec_t mk(input logic v, input int rs0, input int rs1, input logic [1:0] used,
                              input int rd, input logic rw, input logic ld, input logic fl,
                              input logic clr, input logic r, input logic st, input int s0, input int s1);
    vec_t t;
    t.v = v; t.rs0 = 5'(rs0); t.rs1 = 5'(rs1); t.used = used; t.rd = 5'(rd);
    t.rw = rw; t.ld = ld; t.fl = fl; t.clr = clr; t.rs = r; t.st = st;
    t.s0 = 2'(s0); t.s1 = 2'(s1);
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t t, input int idx);
    logic [3:0] want;
    @(negedge clk);
    id_valid    = t.v;
    id_rs       = {t.rs1, t.rs0};
    id_rs_used  = t.used;
    id_rd       = t.rd;
    id_regwrite = t.rw;
    id_is_load  = t.ld;
    flush       = t.fl;
    cnt_clear   = t.clr;
    rst         = t.rs;
    #1;
    chk($sformatf("v%0d stall", idx), int'(stall), int'(t.st));
    chk($sformatf("v%0d pc_write", idx), int'(pc_write), int'(!t.st));
    chk($sformatf("v%0d ifid_write", idx), int'(ifid_write), int'(!t.st));
    chk($sformatf("v%0d idex_bubble", idx), int'(idex_bubble), int'(t.st | t.fl));
    if (exp_q.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL v%0d fwd_sel: scoreboard queue empty", idx);
    end else begin
      want = exp_q.pop_front();
      chk($sformatf("v%0d ex_fwd_sel", idx), int'(ex_fwd_sel), int'(want));
    end
    chk($sformatf("v%0d stall_count", idx), int'(stall_count), exp_cnt);
    exp_q.push_back({t.s1, t.s0});
    if (t.rs || t.clr) exp_cnt = 0;
    else if (t.st && exp_cnt != 7) exp_cnt++;
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rs_used = '0; id_rd = '0;
    id_regwrite = 1'b0; id_is_load = 1'b0; flush = 1'b0; cnt_clear = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.push_back(4'd0);

    //            v  rs0 rs1 used  rd rw ld fl clr rst st s0 s1
    tbl.push_back(mk(1, 0,  0, 2'b01, 5, 1, 0, 0, 0, 0, 0, 0, 0));  // addi x5,x0,3
    tbl.push_back(mk(1, 5,  1, 2'b11, 6, 1, 0, 0, 0, 0, 0, 1, 0));  // add x6,x5,x1 -> EX/MEM fwd
    tbl.push_back(mk(0, 0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1,  0, 2'b01, 5, 1, 1, 0, 0, 0, 0, 0, 0));  // ld x5
    tbl.push_back(mk(1, 1,  5, 2'b11, 7, 1, 0, 0, 0, 0, 1, 0, 0));  // add x7,x1,x5: load-use stall
    tbl.push_back(mk(1, 1,  5, 2'b11, 7, 1, 0, 0, 0, 0, 0, 0, 2));  // retry issues with bus 2
    tbl.push_back(mk(1, 2,  0, 2'b01, 0, 1, 1, 0, 0, 0, 0, 0, 0));  // ld x0 never tracked
    tbl.push_back(mk(1, 0,  7, 2'b11, 8, 1, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 1,  0, 2'b01, 9, 1, 1, 0, 0, 0, 0, 0, 0));  // ld x9
    tbl.push_back(mk(1, 9,  8, 2'b10,10, 1, 0, 0, 0, 0, 0, 0, 2));  // rs0=x9 unused: no stall
    tbl.push_back(mk(1, 0,  0, 2'b00, 7, 1, 0, 0, 0, 0, 0, 0, 0));  // two writers of x7
    tbl.push_back(mk(1, 0,  0, 2'b00, 7, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 7,  7, 2'b11,11, 1, 0, 0, 0, 0, 0, 1, 1));  // youngest x7 wins
    tbl.push_back(mk(1, 0,  0, 2'b00, 5, 1, 1, 0, 0, 0, 0, 0, 0));  // ld x5
    tbl.push_back(mk(1, 5, 11, 2'b11,12, 1, 0, 1, 0, 0, 0, 0, 0));  // hazard under flush
    tbl.push_back(mk(1, 5, 11, 2'b11,13, 1, 0, 0, 0, 0, 0, 0, 0));  // flushed writers gone
    tbl.push_back(mk(1, 0,  0, 2'b00,14, 1, 1, 0, 0, 0, 0, 0, 0));  // ld x14
    tbl.push_back(mk(0,14,  0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // invalid ID never stalls
    tbl.push_back(mk(0, 0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Back-to-back ld x5,0(x5): every second cycle stalls; counter saturates, then clear, then reset.
    for (int k = 1; k <= 27; k++) begin
      logic st;
      st = (k % 2 == 0) && (k != 26);
      tbl.push_back(mk(1, 5, 0, 2'b01, 5, 1, 1, 0, (k == 22), (k == 26), st,
                       (k == 1 || k == 27 || k % 2 == 0) ? 0 : 2, 0));
    end
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
